// File: rtl/funnel_gather.sv
// Width-expanding deserializer: packs RATIO consecutive IN_W-bit beats (LSB beat first)
// into one OUT_W-bit word held in a registered output stage.
module funnel_gather #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [IN_W-1:0]  io_enq_bits,
    input  logic             io_deq_ready,
    output logic             io_deq_valid,
    output logic [OUT_W-1:0] io_deq_bits
);
    localparam int RATIO = OUT_W / IN_W;
    localparam int PTR_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int ACC_W = (RATIO - 1) * IN_W;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(RATIO - 1);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic             out_valid_reg;
    logic             out_valid_next;
    logic [OUT_W-1:0] out_data_reg;
    logic [OUT_W-1:0] out_data_next;

    logic is_last;
    logic enq_fire;
    logic deq_fire;
    logic complete;

    assign is_last      = (ptr_reg == LAST);
    // The final beat may still enter if the held word leaves in the same cycle.
    assign io_enq_ready = !(is_last && out_valid_reg && !io_deq_ready);
    assign enq_fire     = io_enq_valid && io_enq_ready;
    assign deq_fire     = io_deq_ready && out_valid_reg;
    assign complete     = enq_fire && is_last;

    assign io_deq_valid = out_valid_reg;
    assign io_deq_bits  = out_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO - 1; gi++) begin : g_slot
            assign acc_next[gi*IN_W +: IN_W] =
                (enq_fire && (ptr_reg == PTR_W'(gi))) ? io_enq_bits
                                                       : acc_reg[gi*IN_W +: IN_W];
        end
    endgenerate

    always_comb begin
        ptr_next       = ptr_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        if (enq_fire) begin
            // Explicit wrap keeps non-power-of-two ratios correct.
            ptr_next = is_last ? '0 : ptr_reg + PTR_W'(1);
        end
        if (complete) begin
            out_data_next  = {io_enq_bits, acc_reg};
            out_valid_next = 1'b1;
        end else if (deq_fire) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg       <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            acc_reg       <= acc_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end
endmodule

// File: doc/funnel_gather.md
# funnel_gather

Width-expanding deserializer: accepts a stream of narrow `IN_W`-bit beats and packs every `RATIO = OUT_W/IN_W` consecutive beats into one `OUT_W`-bit word, least-significant beat first. It is the receive-side counterpart of the team's funnel serializer, which emits a wide word as narrow beats starting at bits `[IN_W-1:0]`. It sits at the far end of a narrow link and re-forms the original wide words, so serializer→gatherer is an identity path. It has a registered output word so it can keep accepting beats while a completed word waits downstream, sustaining one beat per cycle.

## Interface
Parameters:
- `IN_W`, default 4: input beat width.
- `OUT_W`, default 64: output word width. Must be an integer multiple of `IN_W`, with `RATIO = OUT_W/IN_W >= 2`.

Ports:
- `clock` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `io_enq_valid` input 1: an input beat is presented.
- `io_enq_ready` output 1: block accepts a beat this cycle.
- `io_enq_bits` input `IN_W`: input beat data.
- `io_deq_ready` input 1: downstream accepts a word.
- `io_deq_valid` output 1: a completed word is held.
- `io_deq_bits` output `OUT_W`: completed word.

## Operation
- **State:**
  - `ptr`: beat index, `clog2(RATIO)` bits.
  - `acc`: accumulator, `(RATIO-1)*IN_W` bits.
  - `out_valid`: output register holds a word.
  - `out_data`: output register, `OUT_W` bits.
- **Handshakes:** enq fires when `io_enq_valid & io_enq_ready`. Deq fires when `io_deq_ready & io_deq_valid`.
- **Beat write:** on an enq fire with `ptr < RATIO-1`, the beat is written to `acc[ptr*IN_W +: IN_W]` and `ptr` increments.
- **Word completion:** on an enq fire with `ptr == RATIO-1`:
  - `out_data <= {io_enq_bits, acc}`.
  - `out_valid <= 1`.
  - `ptr` wraps to 0. Wrap is explicit for non-power-of-two `RATIO`.
- **acc contents:** not cleared between words; each slot is overwritten before it is used again.
- **Input ready:** `io_enq_ready = !(ptr == RATIO-1 && out_valid && !io_deq_ready)`.
  - The input stalls only when the completing beat has nowhere to go.
  - Combinational dependency from `io_deq_ready` to `io_enq_ready` is permitted.
- **Output:** `io_deq_valid = out_valid`, `io_deq_bits = out_data`.
- **Deq without completion:** a deq fire with no completion in the same cycle clears `out_valid`. `out_data` holds its stale value and is don't-care while invalid.
- **Simultaneous deq and completion:** the new word loads and `out_valid` stays 1. No bubble.
- **Idle input:** `io_enq_valid = 0` means `ptr` and `acc` hold. Partial words persist indefinitely; there is no timeout and no flush.
- **Data stability:** while `io_deq_valid = 1` and `io_deq_ready = 0`, `io_deq_bits` must not change.

## Timing
- **Reset values (asynchronous assertion):**
  - `ptr = 0`, `acc = 0`, `out_valid = 0`, `out_data = 0`.
  - Hence `io_enq_ready = 1`, `io_deq_valid = 0`, `io_deq_bits = 0`.
  - Deassertion is synchronous to `clock` (externally synchronized).
- **Reset mid-word:** reset discards the partial word and any held output word. The next accepted beat is beat 0.
- **Latency:** the word becomes valid on the cycle after the enq fire of its final beat.
- **Throughput:** one beat per cycle sustained. One word per `RATIO` cycles when `io_deq_ready` is high at least once per `RATIO` cycles.
- **Buffering:** capacity is one full word plus `RATIO-1` beats before the input backpressures.

## Test plan
- **Reset:** assert `reset = 0` at an arbitrary time → `io_enq_ready = 1`, `io_deq_valid = 0`, `io_deq_bits = 0` immediately, without waiting for a clock edge.
- **Single word:** `io_deq_ready = 1`, send beats 0x0..0xF on consecutive cycles → one cycle after beat 0xF, `io_deq_valid = 1` with `io_deq_bits = 64'hFEDCBA9876543210` for exactly one cycle.
- **Backpressure:** `io_deq_ready = 0`, send 32 beats 0x0..0xF,0x0..0xF.
  - `io_enq_ready` drops when `ptr = 15` with word 1 held, and the 32nd beat stalls.
  - Raise `io_deq_ready` → word 1 dequeues in the same cycle the 32nd beat is accepted.
  - Next cycle word 2 (`64'hFEDCBA9876543210`) is valid, with no bubble.
- **Gappy input:** 16 beats with random `io_enq_valid` gaps of 0–5 cycles → same word as the Single word case; `ptr` holds during gaps.
- **Reset mid-word:** send 7 beats, pulse `reset` low, then send 16 beats 0x1..0x0 → `io_deq_bits = 64'h0FEDCBA987654321`, with no residue from the first 7 beats.
- **Streaming:** 64 back-to-back beats with `io_deq_ready = 1` → 4 words, one every 16 cycles, and `io_enq_ready` never drops. Compare the output against a 64-to-4 serializer reference model, checking round-trip identity.
